// File: rtl/pbkdf2_f_ctrl.sv
// pbkdf2_f_ctrl: PBKDF2-HMAC-SHA256 iteration controller.
// Drives one HMAC core through c iterations and XOR-accumulates the
// PRF outputs into one derived-key block T_i.
module pbkdf2_f_ctrl #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              v_i,
    output logic              r_o,
    input  logic [511:0]      key_i,
    input  logic [223:0]      salt_i,
    input  logic [4:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic [31:0]       blk_i,
    output logic              v_o,
    input  logic              r_i,
    output logic [255:0]      dk_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    output logic [511:0]      hmac_key_o,
    output logic [439:0]      hmac_msg_o,
    output logic [4:0]        hmac_len_o,
    input  logic              hmac_v_i,
    output logic              hmac_r_o,
    input  logic [255:0]      hmac_prf_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [511:0]      key_q, key_d;
    logic [439:0]      msg_q, msg_d;
    logic [4:0]        len_q, len_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [255:0]      acc_q, acc_d;

    logic [4:0]        salt_len_c;
    logic [7:0]        salt_bits;
    logic [223:0]      salt_mask;
    logic [439:0]      msg_first;
    logic [ITER_W-1:0] iter_c;

    // First-iteration message: salt truncated to L bytes, INT(i) appended right after it.
    always_comb begin
        salt_len_c = (salt_len_i > 5'd28) ? 5'd28 : salt_len_i;
        salt_bits  = {salt_len_c, 3'b000};
        salt_mask  = ~({224{1'b1}} >> salt_bits);
        msg_first  = {salt_i & salt_mask, 216'b0} | ({blk_i, 408'b0} >> salt_bits);
        iter_c     = (iter_i == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : iter_i;
    end

    // Next-state and datapath update for the request/response loop.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        msg_d   = msg_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    key_d   = key_i;
                    msg_d   = msg_first;
                    len_d   = salt_len_c + 5'd3;
                    cnt_d   = iter_c;
                    acc_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (hmac_r_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (hmac_v_i) begin
                    acc_d   = acc_q ^ hmac_prf_i;
                    msg_d   = {hmac_prf_i, 184'b0};
                    len_d   = 5'd31;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == {{(ITER_W-1){1'b0}}, 1'b1}) ? S_DONE : S_REQ;
                end
            end
            default: begin
                if (r_i) state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake outputs decoded directly from state.
    always_comb begin
        r_o        = (state_q == S_IDLE);
        hmac_v_o   = (state_q == S_REQ);
        hmac_r_o   = (state_q == S_WAIT);
        v_o        = (state_q == S_DONE);
        dk_o       = acc_q;
        hmac_key_o = key_q;
        hmac_msg_o = msg_q;
        hmac_len_o = len_q;
    end

endmodule

// File: tb/tb_pbkdf2_f_ctrl.sv
// Directed bench for pbkdf2_f_ctrl; the bench plays the HMAC core.
module tb_pbkdf2_f_ctrl;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              v_i;
    logic              r_o;
    logic [511:0]      key_i;
    logic [223:0]      salt_i;
    logic [4:0]        salt_len_i;
    logic [31:0]       iter_i;
    logic [31:0]       blk_i;
    logic              v_o;
    logic              r_i;
    logic [255:0]      dk_o;
    logic              hmac_v_o;
    logic              hmac_r_i;
    logic [511:0]      hmac_key_o;
    logic [439:0]      hmac_msg_o;
    logic [4:0]        hmac_len_o;
    logic              hmac_v_i;
    logic              hmac_r_o;
    logic [255:0]      hmac_prf_i;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int hs_mark;

    logic [511:0] key_a;
    logic [255:0] dk_hold;

    pbkdf2_f_ctrl #(.ITER_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .v_i(v_i), .r_o(r_o),
        .key_i(key_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
        .iter_i(iter_i), .blk_i(blk_i), .v_o(v_o), .r_i(r_i), .dk_o(dk_o),
        .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i), .hmac_key_o(hmac_key_o),
        .hmac_msg_o(hmac_msg_o), .hmac_len_o(hmac_len_o), .hmac_v_i(hmac_v_i),
        .hmac_r_o(hmac_r_o), .hmac_prf_i(hmac_prf_i)
    );

    always #5 clk_i = ~clk_i;

    // Count accepted HMAC requests.
    always @(posedge clk_i) begin
        if (hmac_v_o && hmac_r_i) hs_cnt = hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a job at a negedge; DUT accepts on the next posedge.
    task automatic accept(input logic [223:0] salt, input logic [4:0] slen,
                          input logic [31:0] iter, input logic [31:0] blk);
        salt_i     = salt;
        salt_len_i = slen;
        iter_i     = iter;
        blk_i      = blk;
        key_i      = key_a;
        v_i        = 1'b1;
        @(negedge clk_i);
        v_i        = 1'b0;
        key_i      = '1;
        salt_i     = '1;
        blk_i      = '1;
        chk("accept_hmac_v", hmac_v_o, 1'b1);
        chk("accept_r_low", r_o, 1'b0);
    endtask

    // Serve one HMAC iteration with the given request/response stalls.
    task automatic serve(input string tag, input logic [439:0] emsg, input logic [4:0] elen,
                         input logic [255:0] prf, input int unsigned rstall, input int unsigned vstall);
        int unsigned t;
        t = 0;
        while (!hmac_v_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_req_seen"}, hmac_v_o, 1'b1);
        for (int unsigned i = 0; i <= rstall; i++) begin
            chk({tag, "_msg"}, hmac_msg_o, emsg);
            chk({tag, "_len"}, hmac_len_o, elen);
            chk({tag, "_key"}, hmac_key_o, key_a);
            if (i < rstall) @(negedge clk_i);
        end
        hmac_r_i = 1'b1;
        @(negedge clk_i);
        hmac_r_i = 1'b0;
        for (int unsigned i = 0; i <= vstall; i++) begin
            chk({tag, "_wait"}, {hmac_r_o, hmac_v_o}, 2'b10);
            if (i < vstall) @(negedge clk_i);
        end
        hmac_v_i   = 1'b1;
        hmac_prf_i = prf;
        @(negedge clk_i);
        hmac_v_i   = 1'b0;
        hmac_prf_i = ~prf;
    endtask

    task automatic finish_job(input string tag, input logic [255:0] edk);
        chk({tag, "_v_o"}, v_o, 1'b1);
        chk({tag, "_dk"}, dk_o, edk);
        r_i = 1'b1;
        @(negedge clk_i);
        r_i = 1'b0;
        chk({tag, "_idle"}, {r_o, v_o}, 2'b10);
    endtask

    initial begin
        key_a      = {64'h70617373776f7264, 448'b0};   // "password"
        rst_i      = 1'b1;
        v_i        = 1'b0;
        r_i        = 1'b0;
        hmac_r_i   = 1'b0;
        hmac_v_i   = 1'b0;
        hmac_prf_i = '0;
        key_i      = '0;
        salt_i     = '0;
        salt_len_i = '0;
        iter_i     = '0;
        blk_i      = '0;
        v_i        = 1'b1;   // must be ignored while in reset
        repeat (3) @(negedge clk_i);

        // Reset state
        chk("rst_r_o", r_o, 1'b1);
        chk("rst_flags", {v_o, hmac_v_o, hmac_r_o}, 3'b000);
        chk("rst_dk", dk_o, 256'h0);
        chk("rst_key", hmac_key_o, 512'h0);
        chk("rst_msg", hmac_msg_o, 440'h0);
        chk("rst_len", hmac_len_o, 5'd0);
        v_i   = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_idle", {r_o, hmac_v_o}, 2'b10);

        // "salt", L=4, blk 1, c=1, zero-wait HMAC; dk held while r_i low
        accept({32'h73616c74, 192'b0}, 5'd4, 32'd1, 32'd1);
        serve("c1", {32'h73616c74, 32'h00000001, 376'b0}, 5'd7, {8{32'h12345678}}, 0, 0);
        repeat (2) @(negedge clk_i);
        chk("c1_hold_v", v_o, 1'b1);
        finish_job("c1", {8{32'h12345678}});

        // c=3 with stalls: second/third requests carry the previous PRF, len 31
        accept({32'h73616c74, 192'b0}, 5'd4, 32'd3, 32'd1);
        serve("c3a", {32'h73616c74, 32'h00000001, 376'b0}, 5'd7, {32{8'h0F}}, 2, 1);
        serve("c3b", {{32{8'h0F}}, 184'b0}, 5'd31, {32{8'h33}}, 1, 3);
        serve("c3c", {{32{8'h33}}, 184'b0}, 5'd31, {32{8'h55}}, 0, 2);
        finish_job("c3", {32{8'h69}});

        // c=0 treated as 1: exactly one request
        hs_mark = hs_cnt;
        accept({32'h73616c74, 192'b0}, 5'd4, 32'd0, 32'd1);
        serve("c0", {32'h73616c74, 32'h00000001, 376'b0}, 5'd7, 256'hDEADBEEF, 3, 2);
        chk("c0_one_req", hs_cnt - hs_mark, 1);
        finish_job("c0", 256'hDEADBEEF);

        // Message packing at L = 0, 28, 31(->28), salt bytes beyond L zeroed
        accept({28{8'hAA}}, 5'd0, 32'd1, 32'h01020304);
        serve("l0", {32'h01020304, 408'b0}, 5'd3, 256'h1, 0, 0);
        finish_job("l0", 256'h1);
        accept({28{8'hAA}}, 5'd28, 32'd1, 32'h01020304);
        serve("l28", {{28{8'hAA}}, 32'h01020304, 184'b0}, 5'd31, 256'h2, 0, 0);
        finish_job("l28", 256'h2);
        accept({28{8'hAA}}, 5'd31, 32'd1, 32'h01020304);
        serve("l31", {{28{8'hAA}}, 32'h01020304, 184'b0}, 5'd31, 256'h3, 0, 0);
        finish_job("l31", 256'h3);
        accept({28{8'hAA}}, 5'd2, 32'd1, 32'h01020304);
        serve("l2", {16'hAAAA, 32'h01020304, 392'b0}, 5'd5, 256'h4, 0, 0);
        finish_job("l2", 256'h4);

        // Asynchronous reset while in WAIT
        accept({32'h73616c74, 192'b0}, 5'd4, 32'd5, 32'd1);
        hmac_r_i = 1'b1;
        @(negedge clk_i);
        hmac_r_i = 1'b0;
        chk("mid_wait", hmac_r_o, 1'b1);
        #2 rst_i = 1'b1;
        #1 chk("mid_rst_drop", {hmac_r_o, hmac_v_o, v_o, r_o}, 4'b0001);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_after", {r_o, v_o}, 2'b10);
        chk("mid_rst_dk", dk_o, 256'h0);

        // New job completes; v_i held high while result waits for r_i
        accept({32'h73616c74, 192'b0}, 5'd4, 32'd2, 32'd1);
        serve("pr_a", {32'h73616c74, 32'h00000001, 376'b0}, 5'd7, {32{8'hA5}}, 0, 0);
        serve("pr_b", {{32{8'hA5}}, 184'b0}, 5'd31, {32{8'h5A}}, 0, 0);
        hs_mark = hs_cnt;
        v_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            chk("hold_state", {v_o, r_o, hmac_v_o}, 3'b100);
            chk("hold_dk", dk_o, {256{1'b1}});
        end
        v_i = 1'b0;
        chk("hold_no_req", hs_cnt - hs_mark, 0);
        finish_job("pr", {256{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pbkdf2_f_ctrl.md
# pbkdf2_f_ctrl

- Iteration controller for PBKDF2-HMAC-SHA256.
- Computes one derived-key block T_i = U1 ^ U2 ^ … ^ Uc, where:
  - U1 = HMAC(P, S || INT(i));
  - Uj = HMAC(P, U(j−1)).
- Acts as the initiator of the HMAC request/response handshake: it drives the HMAC core's key, message, length and valid signals, and consumes its PRF result.
- Sits between the top-level PBKDF2 sequencer (upstream) and hmac_sha256 (downstream).

## Interface
- ITER_W, 32, width of iteration count and remaining-iteration counter.
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- v_i  in  1  upstream job valid.
- r_o  out  1  upstream ready; high only in IDLE.
- key_i  in  512  password P, left aligned, zero filled on the right.
- salt_i  in  224  salt S, left aligned, max 28 bytes.
- salt_len_i  in  5  salt length in bytes, 0..28; values >28 treated as 28.
- iter_i  in  ITER_W  iteration count c; 0 treated as 1.
- blk_i  in  32  block index i, big-endian INT(i).
- v_o  out  1  result valid.
- r_i  in  1  downstream ready.
- dk_o  out  256  T_i.
- hmac_v_o  out  1  HMAC request valid.
- hmac_r_i  in  1  HMAC request accepted.
- hmac_key_o  out  512  HMAC key (latched P).
- hmac_msg_o  out  440  HMAC message, left aligned.
- hmac_len_o  out  5  message length in bytes minus 1.
- hmac_v_i  in  1  HMAC result valid.
- hmac_r_o  out  1  HMAC result ready.
- hmac_prf_i  in  256  HMAC result.

## Operation
- States: IDLE, REQ, WAIT, DONE. Outputs are decoded from state:
  - r_o = IDLE
  - hmac_v_o = REQ
  - hmac_r_o = WAIT
  - v_o = DONE
- IDLE:
  - On v_i, latch key_i, blk_i, clamped salt length L and clamped count c into cnt.
  - Build msg = ({salt_i with bytes ≥L zeroed, 216'b0}) | ({blk_i, 408'b0} >> 8·L).
  - Set len = L+3 and acc = 0, then go to REQ.
- REQ: hold key, msg and len stable; on hmac_r_i go to WAIT.
- WAIT: on hmac_v_i, in the same edge:
  - acc ^= hmac_prf_i;
  - msg = {hmac_prf_i, 184'b0};
  - len = 31;
  - cnt −= 1.
  - Then go to DONE if cnt was 1, else go to REQ.
- DONE: dk_o = acc; on r_i go to IDLE.
- Ignored inputs:
  - v_i is ignored outside IDLE.
  - hmac_v_i is ignored outside WAIT.
  - hmac_r_i is ignored outside REQ.
- Arithmetic:
  - acc is a 256-bit XOR.
  - cnt is ITER_W unsigned and never wraps, because a count of 0 is replaced by 1 at accept.

## Timing
- Reset (async, any state):
  - state = IDLE;
  - acc, msg, len, cnt, latched key = 0;
  - dk_o = 0;
  - hmac_v_o, hmac_r_o, v_o = 0;
  - r_o = 1; v_i is not sampled while rst_i is high.
- Mid-job reset: the job is discarded; hmac_v_o and hmac_r_o drop immediately. Recovering the HMAC core is the top level's responsibility.
- Accept: v_i & r_o at edge k → hmac_v_o high from cycle k+1.
- Per iteration, with an HMAC that accepts and responds with zero wait, the block adds 2 cycles (REQ + WAIT).
- Total latency is accept → v_o = 1 + Σ(per-iteration cycles) + HMAC latency.
- hmac_msg_o, hmac_len_o and hmac_key_o change only on WAIT→REQ or IDLE→REQ transitions, so they are stable for the whole time hmac_v_o is high.
- dk_o is stable while v_o is high; v_o stays high until r_i.
- Back-to-back jobs: r_i at edge m → IDLE at m+1 → new v_i may be accepted at edge m+1.

## Test plan
- Real hmac_sha256, key "password", salt "salt" (L=4), blk 1, c=1 → dk_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b.
- Same inputs, c=2 → ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
- Same inputs, c=4096 → c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a; exactly 4096 hmac_v_o & hmac_r_i handshakes.
- Behavioural HMAC model (prf = counter value), c=0 with random hmac_r_i and hmac_v_i stalls:
  - exactly one request;
  - hmac_msg_o and hmac_len_o are constant while hmac_v_o is stalled;
  - first-request length is L+3;
  - dk_o equals the model output.
- Message packing with salt_len_i = 0, 28 and 31:
  - INT(i) bytes appear at byte offsets 0, 28 and 28 respectively;
  - hmac_len_o = 3, 31, 31;
  - salt bytes beyond L are 0.
- Assert rst_i in WAIT:
  - hmac_r_o falls in the same cycle;
  - after release, r_o = 1 and v_o = 0;
  - a new job completes correctly;
  - holding r_i = 0 keeps v_o and dk_o stable, with no new accept.
